// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing the instruction memory read port between the
// fetch unit (requester 0) and the debug/loader port (requester 1).
module imem_arbiter #(
    parameter int DEPTH = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [31:0] addr0,
    input  logic        req1,
    input  logic [31:0] addr1,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    output logic [31:0] rdata,
    output logic        ack0,
    output logic        ack1,
    output logic        err,
    output logic        busy
);

    logic        inflight;
    logic        inflight_id;
    logic        pend_err;
    logic        last;
    logic        elig0;
    logic        elig1;
    logic        grant;
    logic        winner;
    logic [31:0] win_addr;

    // A requester with a read still in flight is masked until its ack, so a
    // lone requester is served at most every other cycle.
    always_comb begin
        elig0    = req0 & ~(inflight & ~inflight_id);
        elig1    = req1 & ~(inflight & inflight_id);
        grant    = elig0 | elig1;
        winner   = (elig0 & elig1) ? ~last : elig1;
        win_addr = winner ? addr1 : addr0;
    end

    // Completion of the old read and a new grant may share one edge; the ack
    // uses the old inflight_id while the grant overwrites it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr    <= 32'd0;
            rdata       <= 32'd0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            err         <= 1'b0;
            inflight    <= 1'b0;
            inflight_id <= 1'b0;
            pend_err    <= 1'b0;
            last        <= 1'b1;
        end else begin
            ack0 <= inflight & ~inflight_id;
            ack1 <= inflight & inflight_id;
            err  <= inflight & pend_err;
            if (inflight) begin
                rdata <= mem_data;
            end
            if (grant) begin
                mem_addr    <= win_addr;
                inflight    <= 1'b1;
                inflight_id <= winner;
                last        <= winner;
                pend_err    <= (win_addr >= 32'(DEPTH));
            end else begin
                inflight <= 1'b0;
            end
        end
    end

    assign busy = inflight;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: transaction-level reference model with
// per-cycle comparison, plus directed scenarios with literal expectations.
module tb_imem_arbiter;

    localparam int DEPTH = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0;
    logic [31:0] addr0;
    logic        req1;
    logic [31:0] addr1;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [31:0] rdata;
    logic        ack0;
    logic        ack1;
    logic        err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] image [DEPTH];

    imem_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0),
        .req1(req1), .addr1(addr1),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .rdata(rdata), .ack0(ack0), .ack1(ack1),
        .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memLookup(input logic [31:0] a);
        if (a < 32'(DEPTH)) return image[a[6:0]];
        return 32'hDEADBEEF;
    endfunction

    assign mem_data = memLookup(mem_addr);

    // Reference model: one outstanding read record, completed on the edge
    // after its grant; ties go to whoever was not served last.
    logic        mOut = 1'b0;
    logic        mId = 1'b0;
    logic [31:0] mAddr = 32'd0;
    logic        mLast = 1'b1;
    logic        expAck0 = 1'b0, expAck1 = 1'b0, expErr = 1'b0, expBusy = 1'b0;
    logic [31:0] expRdata = 32'd0, expMemAddr = 32'd0;

    always @(posedge clk or posedge rst) begin
        logic can0, can1, pick;
        if (rst) begin
            mOut = 1'b0; mId = 1'b0; mAddr = 32'd0; mLast = 1'b1;
            expAck0 = 1'b0; expAck1 = 1'b0; expErr = 1'b0; expBusy = 1'b0;
            expRdata = 32'd0; expMemAddr = 32'd0;
        end else begin
            expAck0 = mOut && (mId == 1'b0);
            expAck1 = mOut && (mId == 1'b1);
            expErr  = mOut && (mAddr >= 32'(DEPTH));
            if (mOut) expRdata = memLookup(mAddr);
            can0 = req0 && !(mOut && mId == 1'b0);
            can1 = req1 && !(mOut && mId == 1'b1);
            if (can0 || can1) begin
                pick       = (can0 && can1) ? !mLast : can1;
                mOut       = 1'b1;
                mId        = pick;
                mAddr      = pick ? addr1 : addr0;
                mLast      = pick;
                expMemAddr = mAddr;
            end else begin
                mOut = 1'b0;
            end
            expBusy = mOut;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("model.mem_addr", mem_addr, expMemAddr);
        checkOutput("model.rdata", rdata, expRdata);
        checkOutput("model.ack0", 32'(ack0), 32'(expAck0));
        checkOutput("model.ack1", 32'(ack1), 32'(expAck1));
        checkOutput("model.err", 32'(err), 32'(expErr));
        checkOutput("model.busy", 32'(busy), 32'(expBusy));
        checkOutput("ack.exclusive", 32'(ack0 & ack1), 32'd0);
    end

    task automatic applyStimulus(input logic r0, input logic [31:0] a0,
                                 input logic r1, input logic [31:0] a1);
        req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".mem_addr"}, mem_addr, 32'd0);
        checkOutput({tag, ".rdata"}, rdata, 32'd0);
        checkOutput({tag, ".ack0"}, 32'(ack0), 32'd0);
        checkOutput({tag, ".ack1"}, 32'(ack1), 32'd0);
        checkOutput({tag, ".err"}, 32'(err), 32'd0);
        checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    task automatic resetDut();
        #2 rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; addr0 = 32'd0; addr1 = 32'd0;
        @(negedge clk);
        checkAllZero("reset");
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] iv;
            logic [3:0]  n;
            iv = 32'(i);
            n = iv[3:0];
            image[i] = {n, 20'h0, n, n};
        end
        image[0] = 32'hA00000AA;

        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = 32'd0; addr1 = 32'd0;
        @(negedge clk);
        resetDut();

        // single fetch
        applyStimulus(1'b1, 32'd3, 1'b0, 32'd0);
        checkOutput("fetch.mem_addr", mem_addr, 32'd3);
        checkOutput("fetch.busy", 32'(busy), 32'd1);
        applyStimulus(1'b1, 32'd3, 1'b0, 32'd0);
        checkOutput("fetch.ack0", 32'(ack0), 32'd1);
        checkOutput("fetch.rdata", rdata, 32'h30000033);
        checkOutput("fetch.err", 32'(err), 32'd0);
        checkOutput("fetch.ack1", 32'(ack1), 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0);
        checkOutput("fetch.ack0_off", 32'(ack0), 32'd0);

        // tie and round-robin
        resetDut();
        applyStimulus(1'b1, 32'd1, 1'b1, 32'd2);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 32'd1, 1'b1, 32'd2);
            checkOutput("rr.ack0", 32'(ack0), (k % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput("rr.ack1", 32'(ack1), (k % 2 == 0) ? 32'd0 : 32'd1);
            checkOutput("rr.rdata", rdata, (k % 2 == 0) ? 32'h10000011 : 32'h20000022);
        end
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0);

        // lone requester throughput
        resetDut();
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1'b0, 32'd0, 1'b1, 32'd9);
            checkOutput("lone.ack1", 32'(ack1), (k % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput("lone.busy", 32'(busy), (k % 2 == 0) ? 32'd0 : 32'd1);
            if (k % 2 == 0) checkOutput("lone.rdata", rdata, 32'h90000099);
        end
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0);

        // out-of-range address then in-range
        applyStimulus(1'b1, 32'd200, 1'b0, 32'd0);
        checkOutput("oor.mem_addr", mem_addr, 32'd200);
        applyStimulus(1'b1, 32'd200, 1'b0, 32'd0);
        checkOutput("oor.ack0", 32'(ack0), 32'd1);
        checkOutput("oor.err", 32'(err), 32'd1);
        applyStimulus(1'b1, 32'd0, 1'b0, 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0);
        checkOutput("oor.ack0_next", 32'(ack0), 32'd1);
        checkOutput("oor.err_next", 32'(err), 32'd0);
        checkOutput("oor.rdata_next", rdata, 32'hA00000AA);

        // reset in the middle of a read
        resetDut();
        applyStimulus(1'b0, 32'd0, 1'b1, 32'd9);
        checkOutput("midrst.busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        req1 = 1'b0;
        #1 checkAllZero("midrst");
        @(negedge clk);
        checkOutput("midrst.ack1", 32'(ack1), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        applyStimulus(1'b1, 32'd1, 1'b1, 32'd2);
        checkOutput("midrst.tie_winner", mem_addr, 32'd1);
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0);
        checkOutput("midrst.ack0", 32'(ack0), 32'd1);
        checkOutput("midrst.ack1_after", 32'(ack1), 32'd0);
        checkOutput("midrst.rdata", rdata, 32'h10000011);

        // early drop of req0
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0);
        applyStimulus(1'b1, 32'd3, 1'b0, 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0);
        checkOutput("drop.ack0", 32'(ack0), 32'd1);
        checkOutput("drop.rdata", rdata, 32'h30000033);
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0);
        checkOutput("drop.ack0_once", 32'(ack0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
